// File: rtl/mod_dds_poly_if.sv
// Register-bank inputs and sample outputs of mod_dds_poly.
// master: register/trigger source; slave: the DDS front end.
interface mod_dds_poly_if #(
   parameter int BT = 16,
   parameter int NC = 6,
   parameter int BD = 32,
   parameter int BA = 16
);
   logic             trigger;
   logic [BT-1:0]    WAIT_REG;
   logic [BT-1:0]    LEN_REG;
   logic [NC*BD-1:0] FMOD_C_REG;
   logic [BA-1:0]    AMOD_C0_REG;
   logic [BA-1:0]    AMOD_C1_REG;
   logic [BD-1:0]    POFF_REG;
   logic             WE_REG;
   logic [BD-1:0]    dout_phase;
   logic [BA-1:0]    dout_amp;
   logic             dout_valid;
   logic             busy;

   modport master (
      output trigger, WAIT_REG, LEN_REG, FMOD_C_REG, AMOD_C0_REG, AMOD_C1_REG,
             POFF_REG, WE_REG,
      input  dout_phase, dout_amp, dout_valid, busy
   );

   modport slave (
      input  trigger, WAIT_REG, LEN_REG, FMOD_C_REG, AMOD_C0_REG, AMOD_C1_REG,
             POFF_REG, WE_REG,
      output dout_phase, dout_amp, dout_valid, busy
   );
endinterface

// File: rtl/mod_dds_poly.sv
// Polynomial-FM / linear-AM DDS front end with a double-buffered register bank.
// Define MOD_DDS_POLY_AMP_SAT_EN to clamp the amplitude accumulator instead of wrapping.
module mod_dds_poly #(
   parameter int BT = 16,
   parameter int NC = 6,
   parameter int BD = 32,
   parameter int BA = 16
) (
   input  logic clk,
   input  logic rstn,
   mod_dds_poly_if.slave bus
);
   localparam int AW = BA + BT;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_DONE} state_t;

   typedef struct packed {
      logic [BT-1:0]    wait_n;
      logic [BT-1:0]    len;
      logic [NC*BD-1:0] fc;
      logic [BA-1:0]    a0;
      logic [BA-1:0]    a1;
      logic [BD-1:0]    poff;
   } bank_t;

   state_t state, state_nx;
   bank_t  bank, bank_in, bank_nx;
   logic   trig_q, we_q, pending, pending_nx;
   logic   trig_rise, we_rise, start, rest_now, enter_rest, bank_ld;

   logic [BT-1:0]          wcnt, tcnt;
   logic [NC-1:0][BD-1:0]  d, d_nx;
   logic [BD-1:0]          phase;
   logic [AW-1:0]          acc_a, acc_nx;
   logic signed [AW+1:0]   amp_sum;

   logic [BD-1:0] phase_o;
   logic [BA-1:0] amp_o;
   logic          valid_o;

   assign trig_rise = bus.trigger & ~trig_q;
   assign we_rise   = bus.WE_REG & ~we_q;

   always_comb begin
      bank_in.wait_n = bus.WAIT_REG;
      bank_in.len    = bus.LEN_REG;
      bank_in.fc     = bus.FMOD_C_REG;
      bank_in.a0     = bus.AMOD_C0_REG;
      bank_in.a1     = bus.AMOD_C1_REG;
      bank_in.poff   = bus.POFF_REG;
   end

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      case (state)
         S_IDLE: if (trig_rise) begin
            start    = 1'b1;
            state_nx = (bank_nx.wait_n != '0) ? S_WAIT : S_RUN;
         end
         S_WAIT: begin
            if (!bus.trigger)                        state_nx = S_IDLE;
            else if (wcnt == bank.wait_n - BT'(1))   state_nx = S_RUN;
         end
         S_RUN: begin
            if (!bus.trigger)                        state_nx = S_IDLE;
            else if (bank.len != '0 && tcnt == bank.len - BT'(1)) state_nx = S_DONE;
         end
         S_DONE: if (!bus.trigger) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Writes land immediately when quiescent; during a run they wait for the
   // transition back to IDLE/DONE and take the inputs present at that edge.
   always_comb begin
      rest_now   = (state == S_IDLE) || (state == S_DONE);
      enter_rest = !rest_now && ((state_nx == S_IDLE) || (state_nx == S_DONE));
      bank_ld    = (we_rise && rest_now) || (enter_rest && (pending || we_rise));
      bank_nx    = bank_ld ? bank_in : bank;
      pending_nx = pending;
      if (bank_ld)                  pending_nx = 1'b0;
      else if (we_rise && !rest_now) pending_nx = 1'b1;
   end

   for (genvar k = 0; k < NC; k++) begin : g_diff
      if (k < NC-1) begin : g_acc
         assign d_nx[k] = d[k] + d[k+1];
      end else begin : g_top
         assign d_nx[k] = d[k];
      end
   end

   always_comb begin
      amp_sum = $signed({2'b00, acc_a}) + $signed({{(AW+2-BA){bank.a1[BA-1]}}, bank.a1});
`ifdef MOD_DDS_POLY_AMP_SAT_EN
      if (amp_sum[AW+1])   acc_nx = '0;
      else if (amp_sum[AW]) acc_nx = '1;
      else                  acc_nx = amp_sum[AW-1:0];
`else
      acc_nx = amp_sum[AW-1:0];
`endif
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= S_IDLE;
         bank    <= '0;
         pending <= 1'b0;
         trig_q  <= 1'b0;
         we_q    <= 1'b0;
         wcnt    <= '0;
         tcnt    <= '0;
         d       <= '0;
         phase   <= '0;
         acc_a   <= '0;
         phase_o <= '0;
         amp_o   <= '0;
         valid_o <= 1'b0;
      end else begin
         state   <= state_nx;
         pending <= pending_nx;
         trig_q  <= bus.trigger;
         we_q    <= bus.WE_REG;
         if (bank_ld) bank <= bank_in;
         valid_o <= 1'b0;
         amp_o   <= '0;
         case (state)
            S_IDLE: if (start) begin
               d     <= bank_nx.fc;
               phase <= '0;
               acc_a <= {bank_nx.a0, {BT{1'b0}}};
               tcnt  <= '0;
               wcnt  <= '0;
            end
            S_WAIT: wcnt <= wcnt + BT'(1);
            S_RUN: begin
               valid_o <= 1'b1;
               phase_o <= phase + bank.poff;
               amp_o   <= acc_a[AW-1:BT];
               d       <= d_nx;
               phase   <= phase + d[0];
               acc_a   <= acc_nx;
               tcnt    <= tcnt + BT'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.dout_phase = phase_o;
   assign bus.dout_amp   = amp_o;
   assign bus.dout_valid = valid_o;
   assign bus.busy       = (state == S_WAIT) || (state == S_RUN);
endmodule
